multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style control FSM for the multicycle MIPS datapath.
- Sits directly upstream of the 32-bit enable/reset registers: drives the E inputs of the PC register (pc_en) and the IR register (IRWrite), plus memory, register-file and mux selects.
- Consumes opcode from IR[31:26] and the ALU Zero flag.
- One state per clock; all instruction timing is set by this block.

Parameters:
- None. Opcode width is fixed at 6 bits. Encodings are fixed: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010, bne 000101 (optional).

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high; forces state to FETCH
- Op  input  6  instruction opcode, IR[31:26]
- Zero  input  1  ALU zero flag, valid during BRANCH
- pc_en  output  1  PC register enable, = PCWrite | (Branch & Zero)
- IRWrite  output  1  IR register enable
- MemWrite  output  1  memory write strobe
- RegWrite  output  1  register-file write enable
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- RegDst  output  1  write register select: 0 = rt, 1 = rd
- MemtoReg  output  1  write data select: 0 = ALUOut, 1 = Data
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- ALUOp  output  2  ALU op: 00 = add, 01 = sub, 10 = use funct
- PCSrc  output  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- illegal  output  1  one-cycle pulse on an undefined opcode

Behaviour:
- State register updates on the rising edge of clk. reset=1 at an edge loads FETCH, overriding any transition, including reset mid-instruction.
- While reset=1, every output is forced to 0 combinationally, so no register enable fires during reset.
- Outputs are decoded from state only (Moore). Zero enters only through pc_en, and only in BRANCH. Any output not listed for a state is 0.
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1. Next: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next by Op:
  - lw/sw -> MEMADR
  - R -> EXECUTE
  - beq -> BRANCH
  - addi -> ADDIEX
  - j -> JUMP
  - any other -> FETCH, with illegal=1 for that DECODE cycle
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: MEMRD if lw, MEMWR if sw.
- MEMRD: IorD=1. Next: MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1. Next: FETCH.
- MEMWR: IorD=1, MemWrite=1. Next: FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. Next: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1. Next: FETCH.
- JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
- Cycles per instruction: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Op is sampled only in DECODE and MEMADR. Op changes in other states have no effect.
- An unreachable state encoding recovers to FETCH on the next edge, with all outputs 0 while in it.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_BNE_EN
- Defined: Op=000101 in DECODE -> BRANCH. BRANCH then latches a branch-sense bit (1 for bne, 0 for beq), captured in DECODE and cleared on reset. pc_en in BRANCH = Zero XOR sense.
- Undefined: 000101 is illegal (DECODE -> FETCH, illegal=1). No sense bit is synthesised.

Test Plan (clock period 20):
- reset=1 for 2 edges, Op=100011 -> all outputs 0 during reset. Cycle after release shows FETCH: pc_en=1, IRWrite=1, ALUSrcB=01.
- Op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. IorD=1 in MEMRD. RegWrite=1 with MemtoReg=1 only in cycle 5. Next cycle is FETCH.
- Op=000000 (R), then Op=101011 (sw) -> R: ALUOp=10 in cycle 3, RegWrite=1 and RegDst=1 in cycle 4. sw: MemWrite=1 only in cycle 4, RegWrite never 1.
- Op=000100 (beq), Zero=1 then Zero=0 -> cycle 3: PCSrc=01, ALUOp=01. pc_en=1 with Zero=1, pc_en=0 with Zero=0. Then FETCH.
- Op=000010 (j), then Op=111111 -> j: cycle 3 PCSrc=10, pc_en=1. 111111: illegal=1 in DECODE, FETCH next.
- reset=1 asserted during MEMRD of lw -> FETCH after the edge, RegWrite never asserted. With MULTICYCLE_CONTROL_BNE_EN, Op=000101, Zero=0 -> pc_en=1 in BRANCH.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute and drives datapath enables and selects.
// Optional bne support is enabled by defining MULTICYCLE_CONTROL_BNE_EN.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       pc_en,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MULTICYCLE_CONTROL_BNE_EN
  localparam logic [5:0] OP_BNE  = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  state_t state;
  state_t nextState;
  logic   pcWrite;
  logic   branch;
  logic   decodeIllegal;

  always_comb begin
    nextState     = FETCH;
    decodeIllegal = 1'b0;
    case (state)
      FETCH:   nextState = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECUTE;
          OP_BEQ:       nextState = BRANCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
          OP_BNE:       nextState = BRANCH;
`endif
          OP_ADDI:      nextState = ADDIEX;
          OP_J:         nextState = JUMP;
          default: begin
            nextState     = FETCH;
            decodeIllegal = 1'b1;
          end
        endcase
      end
      MEMADR:  nextState = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nextState = MEMWB;
      EXECUTE: nextState = ALUWB;
      ADDIEX:  nextState = ADDIWB;
      default: nextState = FETCH;
    endcase
  end

`ifdef MULTICYCLE_CONTROL_BNE_EN
  // Branch sense is captured while the opcode is valid in DECODE; BRANCH then uses it to invert Zero.
  logic sense;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      sense <= 1'b0;
    end else begin
      state <= nextState;
      if (state == DECODE)
        sense <= (Op == OP_BNE);
    end
  end
`else
  localparam logic sense = 1'b0;

  always_ff @(posedge clk) begin
    if (reset)
      state <= FETCH;
    else
      state <= nextState;
  end
`endif

  // Moore decode: everything is 0 while reset is held or the state encoding is unreachable.
  always_comb begin
    pcWrite  = 1'b0;
    branch   = 1'b0;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    IorD     = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSrc    = 2'b00;
    illegal  = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          pcWrite = 1'b1;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          illegal = decodeIllegal;
        end
        MEMADR, ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD:   IorD = 1'b1;
        MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = 2'b01;
          branch  = 1'b1;
        end
        ADDIWB:  RegWrite = 1'b1;
        JUMP: begin
          PCSrc   = 2'b10;
          pcWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pc_en = pcWrite | (branch & (Zero ^ sense));

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level cycle model checked every cycle, plus literal spot checks.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'b100011;
  logic       Zero = 1'b0;
  logic       pc_en, IRWrite, MemWrite, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;

  int checks = 0;
  int errors = 0;

`ifdef MULTICYCLE_CONTROL_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero),
    .pc_en(pc_en), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .IorD(IorD), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .illegal(illegal)
  );

  always #10 clk = ~clk;

  function automatic bit isBranchOp(logic [5:0] op);
    return (op == 6'b000100) || (BNE && op == 6'b000101);
  endfunction

  // Cycles per instruction, keyed by opcode; anything unknown costs FETCH + DECODE.
  function automatic int cpi(logic [5:0] op);
    if (op == 6'b100011) return 5;
    if (op == 6'b101011 || op == 6'b000000 || op == 6'b001000) return 4;
    if (isBranchOp(op) || op == 6'b000010) return 3;
    return 2;
  endfunction

  // Expected output vector for cycle 'step' of an instruction with opcode 'op'.
  function automatic logic [14:0] expected(int step, logic [5:0] op, logic z, logic rst);
    logic pe, irw, mw, rw, iord, rd, m2r, asa, il;
    logic [1:0] asb, aop, pcs;
    {pe, irw, mw, rw, iord, rd, m2r, asa, il} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (!rst) begin
      if (step == 0) begin
        pe = 1'b1; irw = 1'b1; asb = 2'b01;
      end else if (step == 1) begin
        asb = 2'b11;
        il  = (cpi(op) == 2);
      end else if (op == 6'b100011 || op == 6'b101011) begin
        if (step == 2) begin asa = 1'b1; asb = 2'b10; end
        else if (step == 3) begin iord = 1'b1; mw = (op == 6'b101011); end
        else begin rw = 1'b1; m2r = 1'b1; end
      end else if (op == 6'b000000) begin
        if (step == 2) begin asa = 1'b1; aop = 2'b10; end
        else begin rw = 1'b1; rd = 1'b1; end
      end else if (op == 6'b001000) begin
        if (step == 2) begin asa = 1'b1; asb = 2'b10; end
        else rw = 1'b1;
      end else if (isBranchOp(op)) begin
        asa = 1'b1; aop = 2'b01; pcs = 2'b01;
        pe  = z ^ (op == 6'b000101);
      end else if (op == 6'b000010) begin
        pcs = 2'b10; pe = 1'b1;
      end
    end
    return {pe, irw, mw, rw, iord, rd, m2r, asa, asb, aop, pcs, il};
  endfunction

  function automatic logic [14:0] actual();
    return {pc_en, IRWrite, MemWrite, RegWrite, IorD, RegDst, MemtoReg, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc, illegal};
  endfunction

  task automatic checkOutput(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Instruction-level model: position within the current instruction and its opcode.
  int         step = 0;
  logic [5:0] dop  = 6'b000000;

  always @(posedge clk) begin
    if (reset) begin
      step = 0;
    end else if (step == 0) begin
      step = 1;
    end else begin
      if (step == 1) dop = Op;
      step = (step + 1 >= cpi(dop)) ? 0 : step + 1;
    end
  end

  always @(negedge clk) begin
    logic [5:0] opNow;
    opNow = (step == 1) ? Op : dop;
    checkOutput($sformatf("model step%0d op%b", step, opNow), {17'd0, actual()},
                {17'd0, expected(step, opNow, Zero, reset)});
  end

  task automatic stepCycles(int n);
    repeat (n) begin
      @(posedge clk);
      #5;
    end
  endtask

  task automatic applyStimulus(logic [5:0] op, logic z);
    Op   = op;
    Zero = z;
    stepCycles(cpi(op));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting multicycle_control bench");
    reset = 1'b1;
    Op    = 6'b100011;
    @(negedge clk);
    checkOutput("reset_all_zero", {17'd0, actual()}, 32'd0);
    stepCycles(2);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("fetch_pc_en", {31'd0, pc_en}, 32'd1);
    checkOutput("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
    checkOutput("fetch_alusrcb", {30'd0, ALUSrcB}, 32'd1);

    // lw walked cycle by cycle
    stepCycles(3);
    @(negedge clk);
    checkOutput("lw_memrd_iord", {31'd0, IorD}, 32'd1);
    stepCycles(1);
    @(negedge clk);
    checkOutput("lw_memwb_regwrite", {30'd0, RegWrite, MemtoReg}, 32'd3);
    stepCycles(1);
    @(negedge clk);
    checkOutput("lw_next_fetch", {31'd0, IRWrite}, 32'd1);

    applyStimulus(6'b000000, 1'b0);
    applyStimulus(6'b101011, 1'b0);
    applyStimulus(6'b001000, 1'b0);

    Op = 6'b000100; Zero = 1'b1;
    stepCycles(2);
    @(negedge clk);
    checkOutput("beq_taken_pc_en", {31'd0, pc_en}, 32'd1);
    checkOutput("beq_pcsrc_aluop", {28'd0, PCSrc, ALUOp}, 32'h5);
    stepCycles(1);
    Zero = 1'b0;
    stepCycles(2);
    @(negedge clk);
    checkOutput("beq_nottaken_pc_en", {31'd0, pc_en}, 32'd0);
    stepCycles(1);

    Op = 6'b000010;
    stepCycles(2);
    @(negedge clk);
    checkOutput("j_pcsrc", {30'd0, PCSrc}, 32'd2);
    stepCycles(1);

    Op = 6'b111111;
    stepCycles(1);
    @(negedge clk);
    checkOutput("illegal_pulse", {31'd0, illegal}, 32'd1);
    stepCycles(1);
    @(negedge clk);
    checkOutput("illegal_then_fetch", {31'd0, IRWrite}, 32'd1);

    // reset while lw sits in MEMRD: the write-back must never happen
    Op = 6'b100011;
    stepCycles(3);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_lw_zero", {17'd0, actual()}, 32'd0);
    stepCycles(1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_mid_lw_fetch", {31'd0, IRWrite}, 32'd1);
    checkOutput("reset_mid_lw_no_regwrite", {31'd0, RegWrite}, 32'd0);

    Op = 6'b000101; Zero = 1'b0;
    stepCycles(1);
    @(negedge clk);
    checkOutput("bne_decode_illegal", {31'd0, illegal}, {31'd0, !BNE});
    if (BNE) begin
      stepCycles(1);
      @(negedge clk);
      checkOutput("bne_taken_pc_en", {31'd0, pc_en}, 32'd1);
      stepCycles(1);
    end else begin
      stepCycles(1);
    end
    applyStimulus(6'b000101, 1'b1);
    applyStimulus(6'b000000, 1'b0);
    applyStimulus(6'b100011, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
